// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit common-anode 7-segment driver with BCD decode,
// leading-zero blanking and a frame-aligned ready/load value update.
module seg7_scan_ctrl #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2,
    parameter int BLANK_LZ    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   value,
    output logic                    ready,
    output logic [N_DIGITS-1:0]     an,
    output logic [6:0]              seg
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [PW-1:0] PS_MAX   = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] PS_GUARD = PW'(GUARD);
    localparam logic [IW-1:0] IDX_MAX  = IW'(N_DIGITS - 1);
    localparam bit            BLANK_EN = (BLANK_LZ != 0);

    typedef enum logic {PH_GUARD, PH_DRIVE} phase_e;

    logic [PW-1:0]           prescaler_q;
    logic [IW-1:0]           idx_q;
    logic [4*N_DIGITS-1:0]   disp_q;
    logic [4*N_DIGITS-1:0]   pend_q;
    logic                    pending_q;
    logic                    ready_q;
    logic [N_DIGITS-1:0]     an_q;
    logic [6:0]              seg_q;

    logic                    tick;
    logic                    frame_end;
    phase_e                  phase_d;
    logic [N_DIGITS-1:0]     an_d;
    logic [6:0]              seg_d;
    logic [3:0]              digit [N_DIGITS];
    logic [N_DIGITS-1:0]     zero_hi;

    // zero_hi[i] is set when digit i and every more significant digit are zero.
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign digit[gi] = disp_q[4*gi +: 4];
            if (gi == N_DIGITS - 1) begin : g_top
                assign zero_hi[gi] = (disp_q[4*gi +: 4] == 4'd0);
            end else begin : g_low
                assign zero_hi[gi] = (disp_q[4*gi +: 4] == 4'd0) && zero_hi[gi+1];
            end
        end
    endgenerate

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0011000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    assign tick      = (prescaler_q == PS_MAX);
    assign frame_end = tick && (idx_q == IDX_MAX);

    // Output next-state is derived from the current counters so an/seg lag them by one cycle.
    always_comb begin
        phase_d = (prescaler_q < PS_GUARD) ? PH_GUARD : PH_DRIVE;
        an_d    = '1;
        seg_d   = 7'h7F;
        if (phase_d == PH_DRIVE) begin
            an_d = ~(N_DIGITS'(1) << idx_q);
            if (BLANK_EN && (idx_q != '0) && zero_hi[idx_q]) begin
                seg_d = 7'h7F;
            end else begin
                seg_d = decode(digit[idx_q]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_q <= '0;
            idx_q       <= '0;
            disp_q      <= '0;
            pend_q      <= '0;
            pending_q   <= 1'b0;
            ready_q     <= 1'b1;
            an_q        <= '1;
            seg_q       <= 7'h7F;
        end else begin
            prescaler_q <= tick ? '0 : prescaler_q + 1'b1;
            if (tick) begin
                idx_q <= (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
            end
            // A pending value implies ready is low, so the two branches never compete.
            if (frame_end && pending_q) begin
                disp_q    <= pend_q;
                pending_q <= 1'b0;
                ready_q   <= 1'b1;
            end else if (load && ready_q) begin
                pend_q    <= value;
                pending_q <= 1'b1;
                ready_q   <= 1'b0;
            end
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign ready = ready_q;
    assign an    = an_q;
    assign seg   = seg_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl (4 digits, 8-cycle slots, 2-cycle guard).
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0000;
    logic        ready;
    logic [3:0]  an;
    logic [6:0]  seg;

    int checks = 0;
    int errors = 0;
    // Frame position reflected by an/seg; 0 is the first cycle after reset release.
    int pos = -1;

    seg7_scan_ctrl #(
        .N_DIGITS(4), .REFRESH_DIV(8), .GUARD(2), .BLANK_LZ(1)
    ) dut (
        .clk(clk), .reset(reset), .load(load), .value(value),
        .ready(ready), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        pos++;
    endtask

    task automatic goto(input int target);
        while (pos < target) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        load  = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        pos   = -1;
    endtask

    task automatic load_at(input int p, input logic [15:0] v);
        goto(p);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if ({ready, an, seg} !== {1'b1, 4'b1111, 7'h7F}) begin
            errors++;
            $display("FAIL reset_hold: got ready=%b an=%b seg=%b expected 1 1111 1111111", ready, an, seg);
        end
        reset = 1'b0;
        pos = -1;
        goto(1);
        checks++;
        if ({an, seg} !== {4'b1111, 7'h7F}) begin
            errors++;
            $display("FAIL reset_guard: got an=%b seg=%b expected 1111 1111111", an, seg);
        end
        goto(2);
        checks++;
        if ({an, seg} !== {4'b1110, 7'h40}) begin
            errors++;
            $display("FAIL reset_first_drive: got an=%b seg=%b expected 1110 1000000", an, seg);
        end
        goto(10);
        checks++;
        if ({an, seg} !== {4'b1101, 7'h7F}) begin
            errors++;
            $display("FAIL reset_blank_slot1: got an=%b seg=%b expected 1101 1111111", an, seg);
        end
        $display("test_reset done");
    endtask

    task automatic test_load_0042();
        do_reset();
        step();
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL t2_ready_idle: got %b expected 1", ready);
        end
        load_at(0, 16'h0042);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL t2_ready_low: got %b expected 0", ready);
        end
        goto(30);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL t2_ready_before_fe: got %b expected 0", ready);
        end
        goto(31);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL t2_ready_after_fe: got %b expected 1", ready);
        end
        goto(34);
        checks++;
        if ({an, seg} !== {4'b1110, 7'h24}) begin
            errors++;
            $display("FAIL t2_slot0: got an=%b seg=%b expected 1110 0100100", an, seg);
        end
        goto(42);
        checks++;
        if ({an, seg} !== {4'b1101, 7'h19}) begin
            errors++;
            $display("FAIL t2_slot1: got an=%b seg=%b expected 1101 0011001", an, seg);
        end
        goto(50);
        checks++;
        if ({an, seg} !== {4'b1011, 7'h7F}) begin
            errors++;
            $display("FAIL t2_slot2: got an=%b seg=%b expected 1011 1111111", an, seg);
        end
        goto(58);
        checks++;
        if ({an, seg} !== {4'b0111, 7'h7F}) begin
            errors++;
            $display("FAIL t2_slot3: got an=%b seg=%b expected 0111 1111111", an, seg);
        end
        $display("test_load_0042 done");
    endtask

    task automatic test_inner_zeros();
        do_reset();
        load_at(0, 16'h1000);
        goto(34);
        checks++;
        if ({an, seg} !== {4'b1110, 7'h40}) begin
            errors++;
            $display("FAIL t3_slot0: got an=%b seg=%b expected 1110 1000000", an, seg);
        end
        goto(42);
        checks++;
        if ({an, seg} !== {4'b1101, 7'h40}) begin
            errors++;
            $display("FAIL t3_slot1: got an=%b seg=%b expected 1101 1000000", an, seg);
        end
        goto(50);
        checks++;
        if ({an, seg} !== {4'b1011, 7'h40}) begin
            errors++;
            $display("FAIL t3_slot2: got an=%b seg=%b expected 1011 1000000", an, seg);
        end
        goto(58);
        checks++;
        if ({an, seg} !== {4'b0111, 7'h79}) begin
            errors++;
            $display("FAIL t3_slot3: got an=%b seg=%b expected 0111 1111001", an, seg);
        end
        $display("test_inner_zeros done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        // Load is sampled on the frame_end edge, so the transfer slips a whole frame.
        load_at(30, 16'h0007);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL t4_ready_low: got %b expected 0", ready);
        end
        load_at(31, 16'h0009);
        goto(34);
        checks++;
        if ({an, seg} !== {4'b1110, 7'h40}) begin
            errors++;
            $display("FAIL t4_old_frame: got an=%b seg=%b expected 1110 1000000", an, seg);
        end
        goto(62);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL t4_ready_hold: got %b expected 0", ready);
        end
        goto(63);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL t4_ready_release: got %b expected 1", ready);
        end
        goto(66);
        checks++;
        if ({an, seg} !== {4'b1110, 7'h78}) begin
            errors++;
            $display("FAIL t4_new_frame: got an=%b seg=%b expected 1110 1111000", an, seg);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_non_bcd();
        do_reset();
        load_at(0, 16'h05A3);
        goto(34);
        checks++;
        if ({an, seg} !== {4'b1110, 7'h30}) begin
            errors++;
            $display("FAIL t5_slot0: got an=%b seg=%b expected 1110 0110000", an, seg);
        end
        goto(42);
        checks++;
        if ({an, seg} !== {4'b1101, 7'h7F}) begin
            errors++;
            $display("FAIL t5_slot1: got an=%b seg=%b expected 1101 1111111", an, seg);
        end
        goto(50);
        checks++;
        if ({an, seg} !== {4'b1011, 7'h12}) begin
            errors++;
            $display("FAIL t5_slot2: got an=%b seg=%b expected 1011 0010010", an, seg);
        end
        goto(58);
        checks++;
        if ({an, seg} !== {4'b0111, 7'h7F}) begin
            errors++;
            $display("FAIL t5_slot3: got an=%b seg=%b expected 0111 1111111", an, seg);
        end
        $display("test_non_bcd done");
    endtask

    task automatic test_reset_pending();
        do_reset();
        load_at(0, 16'h0008);
        goto(3);
        checks++;
        if ({ready, an, seg} !== {1'b0, 4'b1110, 7'h40}) begin
            errors++;
            $display("FAIL t6_pre: got ready=%b an=%b seg=%b expected 0 1110 1000000", ready, an, seg);
        end
        reset = 1'b1;
        step();
        checks++;
        if ({ready, an, seg} !== {1'b1, 4'b1111, 7'h7F}) begin
            errors++;
            $display("FAIL t6_reset: got ready=%b an=%b seg=%b expected 1 1111 1111111", ready, an, seg);
        end
        reset = 1'b0;
        pos = -1;
        goto(34);
        checks++;
        if ({ready, an, seg} !== {1'b1, 4'b1110, 7'h40}) begin
            errors++;
            $display("FAIL t6_discarded: got ready=%b an=%b seg=%b expected 1 1110 1000000", ready, an, seg);
        end
        $display("test_reset_pending done");
    endtask

    initial begin
        test_reset();
        test_load_0042();
        test_inner_zeros();
        test_back_to_back();
        test_non_bcd();
        test_reset_pending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
